// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares the single read port and single write port of register_file between
//   requester A (core pipeline) and requester B (load/store path).
//   One request is accepted per cycle with round-robin fairness. The register
//   file ports are driven combinationally from the granted request. A response
//   pulse is registered one cycle after acceptance.
//
//   Optional feature, macro RF_ARB_LOCK_EN: an accepted request with lock=1 pins
//   the ports to that requester until it issues an accepted lock=0 request, or
//   until LOCK_MAX cycles have passed. If the macro is undefined, the lock
//   inputs are ignored and the arbiter is pure round-robin.
//
// Ports
//   clk, reset                     clock, async active-high reset
//   {a,b}_req_valid/we/addr/wdata  request channel
//   {a,b}_req_lock                 request/hold lock
//   {a,b}_req_ready                grant (accept on valid && ready)
//   {a,b}_rsp_valid/data           one-cycle response, data = 0 for writes
//   rf_read_reg, rf_read_data      register_file read port 1
//   rf_write_reg/reg_write/write_data  register_file write port
//   locked                         lock FSM not idle
module rf_port_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req_valid,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  input  logic              a_req_lock,
  output logic              a_req_ready,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req_valid,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  input  logic              b_req_lock,
  output logic              b_req_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic              rf_reg_write,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              locked
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             last_grant, last_grant_nxt;   // 0 = A, 1 = B
  logic             gnt_a, gnt_b, gnt_any;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rsp_val;

`ifndef RF_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = a_req_lock ^ b_req_lock;
`endif

  // Grants are forced low during reset so nothing reaches the register file.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      case (state)
        LOCK_A:  gnt_a = a_req_valid;
        LOCK_B:  gnt_b = b_req_valid;
        default: begin
          if (a_req_valid && b_req_valid) begin
            gnt_a = last_grant;
            gnt_b = !last_grant;
          end else begin
            gnt_a = a_req_valid;
            gnt_b = b_req_valid;
          end
        end
      endcase
    end
  end

  assign a_req_ready = gnt_a;
  assign b_req_ready = gnt_b;
  assign gnt_any     = gnt_a | gnt_b;
  assign sel_we      = gnt_b ? b_req_we    : a_req_we;
  assign sel_addr    = gnt_b ? b_req_addr  : a_req_addr;
  assign sel_wdata   = gnt_b ? b_req_wdata : a_req_wdata;

  always_comb begin
    rf_read_reg   = '0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    if (gnt_any) begin
      rf_read_reg   = sel_addr;
      rf_write_reg  = sel_addr;
      rf_write_data = sel_wdata;
      rf_reg_write  = sel_we && (sel_addr != '0);
    end
  end

  // x0 reads as zero regardless of what the register file returns.
  assign rsp_val = (sel_we || sel_addr == '0) ? '0 : rf_read_data;

  always_comb begin
    state_nxt      = state;
    lock_cnt_nxt   = lock_cnt;
    last_grant_nxt = last_grant;
    if (gnt_a)      last_grant_nxt = 1'b0;
    else if (gnt_b) last_grant_nxt = 1'b1;
`ifdef RF_ARB_LOCK_EN
    case (state)
      IDLE: begin
        lock_cnt_nxt = '0;
        if (gnt_a && a_req_lock)      state_nxt = LOCK_A;
        else if (gnt_b && b_req_lock) state_nxt = LOCK_B;
      end
      LOCK_A: begin
        if (gnt_a && !a_req_lock) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else if (lock_cnt == CNT_LAST) begin
          // Timeout: mark A as last served so B wins the next contention.
          state_nxt      = IDLE;
          lock_cnt_nxt   = '0;
          last_grant_nxt = 1'b0;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      LOCK_B: begin
        if (gnt_b && !b_req_lock) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else if (lock_cnt == CNT_LAST) begin
          state_nxt      = IDLE;
          lock_cnt_nxt   = '0;
          last_grant_nxt = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
`endif
  end

  assign locked = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      last_grant  <= 1'b1;
      a_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_valid <= 1'b0;
      b_rsp_data  <= '0;
    end else begin
      state       <= state_nxt;
      lock_cnt    <= lock_cnt_nxt;
      last_grant  <= last_grant_nxt;
      a_rsp_valid <= gnt_a;
      b_rsp_valid <= gnt_b;
      if (gnt_a) a_rsp_data <= rsp_val;
      if (gnt_b) b_rsp_data <= rsp_val;
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: register-file environment plus a behavioural
// arbitration model; directed scenarios followed by randomized traffic.
module tb_rf_port_arbiter;
  localparam int DW = 64, AW = 5, LM = 16;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          lk;
  } req_t;

  logic clk = 1'b0, reset = 1'b1;
  logic a_req_valid, a_req_we, a_req_lock, a_req_ready, a_rsp_valid;
  logic b_req_valid, b_req_we, b_req_lock, b_req_ready, b_rsp_valid;
  logic [AW-1:0] a_req_addr, b_req_addr, rf_read_reg, rf_write_reg;
  logic [DW-1:0] a_req_wdata, b_req_wdata, a_rsp_data, b_rsp_data;
  logic [DW-1:0] rf_read_data, rf_write_data;
  logic rf_reg_write, locked;

  always #5 clk = ~clk;

  rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_req_lock(a_req_lock), .a_req_ready(a_req_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_req_lock(b_req_lock), .b_req_ready(b_req_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .rf_write_reg(rf_write_reg), .rf_reg_write(rf_reg_write),
    .rf_write_data(rf_write_data), .locked(locked)
  );

  // Register file environment (x0 deliberately holds junk).
  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 3) return 64'h1234;
    if (i == 0) return 64'hBAD0_BAD0_BAD0_BAD0;
    return {32'hC0DE_0000, 32'(i * 17 + 5)};
  endfunction

  logic mem_init = 1'b1;
  logic [DW-1:0] rf_mem [32];
  assign rf_read_data = rf_mem[rf_read_reg];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
    end else if (rf_reg_write) begin
      rf_mem[rf_write_reg] <= rf_write_data;
    end
  end

  // Behavioural model state.
  logic [DW-1:0] mref [32];
  int m_last;                 // requester served most recently, 0=A 1=B
  int m_lock;                 // 0 none, 1 A holds, 2 B holds
  int m_cnt;                  // cycles spent holding
  logic exp_av, exp_bv;
  logic [DW-1:0] exp_ad, exp_bd;
  logic seen_ga, seen_gb, seen_we;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic req_t mk(input logic v, input logic we, input int addr,
                              input logic [DW-1:0] wd, input logic lk);
    req_t r;
    r.v = v; r.we = we; r.addr = AW'(addr); r.wd = wd; r.lk = lk;
    return r;
  endfunction

  task automatic drive(input req_t ra, input req_t rb);
    a_req_valid = ra.v; a_req_we = ra.we; a_req_addr = ra.addr;
    a_req_wdata = ra.wd; a_req_lock = ra.lk;
    b_req_valid = rb.v; b_req_we = rb.we; b_req_addr = rb.addr;
    b_req_wdata = rb.wd; b_req_lock = rb.lk;
  endtask

  task automatic model_reset();
    m_last = 1; m_lock = 0; m_cnt = 0;
    exp_av = 1'b0; exp_bv = 1'b0; exp_ad = '0; exp_bd = '0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc(input req_t ra, input req_t rb);
    logic wa, wb, ea, eb;
    req_t w;
    logic [DW-1:0] rd;
    chk("a_rsp_valid", a_rsp_valid, exp_av);
    chk("a_rsp_data",  a_rsp_data,  exp_ad);
    chk("b_rsp_valid", b_rsp_valid, exp_bv);
    chk("b_rsp_data",  b_rsp_data,  exp_bd);
    chk("locked", locked, m_lock != 0);
    drive(ra, rb);
    #1;
    ea = ra.v && (m_lock != 2);
    eb = rb.v && (m_lock != 1);
    wa = ea && (!eb || m_last == 1);
    wb = eb && !wa;
    w  = wb ? rb : ra;
    chk("a_req_ready", a_req_ready, wa);
    chk("b_req_ready", b_req_ready, wb);
    chk("rf_read_reg",   rf_read_reg,   (wa || wb) ? w.addr : '0);
    chk("rf_write_reg",  rf_write_reg,  (wa || wb) ? w.addr : '0);
    chk("rf_write_data", rf_write_data, (wa || wb) ? w.wd : '0);
    chk("rf_reg_write",  rf_reg_write,  (wa || wb) && w.we && w.addr != 0);
    seen_ga = a_req_ready; seen_gb = b_req_ready; seen_we = rf_reg_write;
    // Effects of this cycle's acceptance, visible after the edge.
    rd = (w.we || w.addr == 0) ? '0 : mref[w.addr];
    exp_av = wa; exp_bv = wb;
    if (wa) exp_ad = rd;
    if (wb) exp_bd = rd;
    if ((wa || wb) && w.we && w.addr != 0) mref[w.addr] = w.wd;
    if (wa) m_last = 0;
    if (wb) m_last = 1;
`ifdef RF_ARB_LOCK_EN
    if (m_lock == 0) begin
      m_cnt = 0;
      if ((wa || wb) && w.lk) m_lock = wa ? 1 : 2;
    end else if ((wa || wb) && !w.lk) begin
      m_lock = 0; m_cnt = 0;
    end else if (m_cnt == LM - 1) begin
      m_last = m_lock - 1; m_lock = 0; m_cnt = 0;
    end else begin
      m_cnt++;
    end
`endif
    @(negedge clk);
  endtask

  // Called at a negedge with reset low or high; returns at a negedge with reset low.
  task automatic do_reset();
    reset = 1'b1;
    drive(mk(1, 1, 9, 64'h5555, 1), mk(1, 1, 10, 64'h6666, 1));
    #1;
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_b_ready", b_req_ready, 0);
    chk("rst_rf_reg_write", rf_reg_write, 0);
    chk("rst_rf_read_reg", rf_read_reg, 0);
    chk("rst_rf_write_data", rf_write_data, 0);
    chk("rst_a_rsp", {a_rsp_valid, a_rsp_data}, 0);
    chk("rst_b_rsp", {b_rsp_valid, b_rsp_data}, 0);
    chk("rst_locked", locked, 0);
    @(negedge clk);
    reset = 1'b0;
    drive('0, '0);
    model_reset();
  endtask

  initial begin
    int first_b;
    drive('0, '0);
    model_reset();
    for (int i = 0; i < 32; i++) mref[i] = init_val(i);
    @(negedge clk);
    do_reset();
    mem_init = 1'b0;

    // Fairness: continuous reads of x3 from both; A wins first.
    for (int i = 0; i < 6; i++) begin
      cyc(mk(1, 0, 3, 0, 0), mk(1, 0, 3, 0, 0));
      chk("fair_grant_a", seen_ga, (i % 2) == 0);
      chk("fair_rsp", (i % 2 == 0) ? a_rsp_data : b_rsp_data, 64'h1234);
    end

    // x0 handling.
    cyc(mk(0, 0, 0, 0, 0), mk(1, 1, 0, 64'hFFFF, 0));
    chk("x0_wr_suppressed", seen_we, 0);
    chk("x0_wr_ack", b_rsp_valid, 1);
    cyc(mk(1, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    chk("x0_rd_zero", a_rsp_data, 0);

    // Read after write.
    cyc(mk(1, 1, 7, 64'hDEADBEEF, 0), mk(0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0), mk(1, 0, 7, 0, 0));
    chk("raw_data", b_rsp_data, 64'hDEADBEEF);

`ifdef RF_ARB_LOCK_EN
    // Locked sequence: B held off until A's lock=0 op.
    cyc(mk(1, 0, 3, 0, 1), mk(1, 0, 4, 0, 0));
    chk("lk_b_ready0", seen_gb, 0);
    cyc(mk(1, 1, 5, 64'h55, 1), mk(1, 0, 4, 0, 0));
    chk("lk_b_ready1", seen_gb, 0);
    cyc(mk(1, 0, 5, 0, 0), mk(1, 0, 4, 0, 0));
    chk("lk_b_ready2", seen_gb, 0);
    cyc(mk(1, 0, 3, 0, 0), mk(1, 0, 4, 0, 0));
    chk("lk_b_after", seen_gb, 1);

    // Timeout release.
    first_b = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(mk(1, 0, 3, 0, 1), mk(1, 0, 4, 0, 0));
      if (seen_gb && first_b < 0) first_b = i;
    end
    chk("lk_force_first_b", 64'(first_b), 64'd17);

    // Reset while B holds the lock.
    do_reset();
    cyc(mk(0, 0, 0, 0, 0), mk(1, 0, 6, 0, 1));
    cyc(mk(0, 0, 0, 0, 0), mk(1, 0, 6, 0, 1));
    chk("lk_b_held", locked, 1);
`else
    first_b = 0;
    cyc(mk(1, 0, 3, 0, 1), mk(1, 0, 4, 0, 1));
    chk("nolock_locked", locked, 0);
`endif
    do_reset();
    cyc(mk(1, 0, 3, 0, 0), mk(1, 0, 4, 0, 0));
    chk("post_rst_a_first", seen_ga, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      req_t ra, rb;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        ra = mk($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7), {$urandom, $urandom}, $urandom_range(0, 5) == 0);
        rb = mk($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7), {$urandom, $urandom}, $urandom_range(0, 5) == 0);
        cyc(ra, rb);
      end
    end
    cyc('0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Shares the single read port and single write port of `register_file` between two requesters: requester A (core pipeline) and requester B (load/store path). It accepts one request per cycle with round-robin fairness and drives the register-file ports from the granted request. It returns a registered response one cycle after acceptance. An optional lock mode lets one requester hold the ports for an atomic multi-access sequence, bounded by a timeout.

## Interface
Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register index width
- LOCK_MAX, 16, maximum cycles a lock may be held (≥2)

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- a_req_valid / b_req_valid  input  1  request present
- a_req_we / b_req_we  input  1  1 = write, 0 = read
- a_req_addr / b_req_addr  input  ADDR_W  register index
- a_req_wdata / b_req_wdata  input  DATA_W  write data
- a_req_lock / b_req_lock  input  1  request/hold lock (used only with RF_ARB_LOCK_EN)
- a_req_ready / b_req_ready  output  1  grant; accept when valid&&ready at posedge
- a_rsp_valid / b_rsp_valid  output  1  one-cycle response pulse
- a_rsp_data / b_rsp_data  output  DATA_W  read result; 0 for writes
- rf_read_reg  output  ADDR_W  to register_file read_reg1
- rf_read_data  input  DATA_W  from register_file read_data1 (combinational)
- rf_write_reg  output  ADDR_W  to register_file write_reg
- rf_reg_write  output  1  to register_file reg_write
- rf_write_data  output  DATA_W  to register_file write_data
- locked  output  1  lock FSM not in IDLE

## Operation
- Registers: `last_grant` (0=A, 1=B), FSM state {IDLE, LOCK_A, LOCK_B}, `lock_cnt`, and the response registers.
- Grant is combinational in IDLE:
  - Only one requester valid → grant it.
  - Both valid → grant the one that is not `last_grant`.
  - At most one ready high per cycle; ready is 0 when the requester is not valid.
- `last_grant` updates only on acceptance.
- Port drive is combinational from the granted request:
  - rf_read_reg = addr.
  - rf_write_reg = addr.
  - rf_write_data = wdata.
  - rf_reg_write = accepted && we && addr≠0.
- With no grant, all rf outputs are 0.
- Writes to x0 are accepted and acknowledged but never written.
- Responses, registered at the accept edge, to the accepting requester:
  - rsp_valid=1.
  - Read: rsp_data = rf_read_data, or 0 if addr=0.
  - Write: rsp_data = 0.
- The other requester's rsp_valid=0 and rsp_data holds its last value.
- There is no response backpressure. Requesters must sink the response.

## Timing
- Reset values:
  - All ready = 0, rsp_valid = 0, rsp_data = 0, rf_* = 0.
  - locked = 0, state IDLE, lock_cnt = 0.
  - last_grant = B, so A wins the first contention.
- Latency:
  - Grant: same cycle as valid.
  - Response: exactly 1 cycle after acceptance.
  - Throughput: 1 op per cycle.
- Read after write: a read accepted in the cycle after a write to the same register returns the new value, because the register file writes at posedge.
- Reset mid-operation:
  - Pending responses are dropped.
  - FSM returns to IDLE.
  - No rf_reg_write is generated while reset is high.

## Configuration
- Macro `RF_ARB_LOCK_EN`:
  - **Defined.** An accepted request with lock=1 moves the FSM to LOCK_x. In LOCK_x only x is granted; the other requester's ready is 0 even if x is idle. lock_cnt increments every cycle in LOCK_x. The FSM returns to IDLE on either of:
    - an accepted x request with lock=0 (that request completes normally);
    - lock_cnt reaching LOCK_MAX−1 (forced release; last_grant set to x so the other requester wins the next contention).
  - **Undefined.** Lock inputs are ignored, FSM stays IDLE, locked = 0, and the arbiter is pure round-robin.

## Test plan
- **Reset defaults.** Assert reset → all outputs 0. Then A and B both valid → A granted first.
- **Fairness.** A and B both issue continuous reads of x3 (=0x1234) → grants alternate A,B,A,B; each rsp_valid pulse comes 1 cycle after acceptance with rsp_data=0x1234.
- **x0 handling.**
  - B writes x0 ← 0xFFFF → acknowledged with rf_reg_write=0.
  - A then reads x0 → rsp_data=0.
- **Read after write.** A writes x7 ← 0xDEADBEEF, then B reads x7 in the next cycle → b_rsp_data=0xDEADBEEF.
- **Lock (RF_ARB_LOCK_EN).**
  - A issues 3 locked ops while B is continuously valid → B_ready=0 throughout; A's final lock=0 op releases; B is granted the next cycle.
  - A holds lock=1 for more than 16 cycles → forced release at LOCK_MAX; B is granted.
- **Reset mid-lock.** Assert reset while in LOCK_B → locked=0 and state IDLE; after reset, A is granted.
